// File: rtl/ex_stage.sv
// ex_stage: execute stage fed by the ID/EX register.
// Computes logic/shift/arith/move results, owns HI/LO, runs single-cycle MULT/MULTU
// and a 32-step restoring divider for DIV/DIVU that stalls the pipeline while busy.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   aluop_i, alusel_i   operation code and result class
//   reg1_i, reg2_i      operands (dividend/divisor, shift source/amount)
//   wd_i, wreg_i        destination address / write enable, passed through
//   annul_i             flush: abort any divide in progress
//   wd_o, wreg_o        destination to EX/MEM
//   wdata_o             combinational result
//   hi_o, lo_o          current HI/LO registers
//   stallreq_o          hold upstream stages this cycle
module ex_stage #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] OpAnd   = 8'b0010_0100;
    localparam logic [7:0] OpOr    = 8'b0010_0101;
    localparam logic [7:0] OpXor   = 8'b0010_0110;
    localparam logic [7:0] OpNor   = 8'b0010_0111;
    localparam logic [7:0] OpSll   = 8'b0111_1100;
    localparam logic [7:0] OpSrl   = 8'b0000_0010;
    localparam logic [7:0] OpSra   = 8'b0000_0011;
    localparam logic [7:0] OpAdd   = 8'b0010_0000;
    localparam logic [7:0] OpAddu  = 8'b0010_0001;
    localparam logic [7:0] OpSub   = 8'b0010_0010;
    localparam logic [7:0] OpSubu  = 8'b0010_0011;
    localparam logic [7:0] OpSlt   = 8'b0010_1010;
    localparam logic [7:0] OpSltu  = 8'b0010_1011;
    localparam logic [7:0] OpMult  = 8'b0001_1000;
    localparam logic [7:0] OpMultu = 8'b0001_1001;
    localparam logic [7:0] OpDiv   = 8'b0001_1010;
    localparam logic [7:0] OpDivu  = 8'b0001_1011;
    localparam logic [7:0] OpMfhi  = 8'b0001_0000;
    localparam logic [7:0] OpMthi  = 8'b0001_0001;
    localparam logic [7:0] OpMflo  = 8'b0001_0010;
    localparam logic [7:0] OpMtlo  = 8'b0001_0011;

    localparam logic [2:0] SelLogic = 3'b001;
    localparam logic [2:0] SelShift = 3'b010;
    localparam logic [2:0] SelMove  = 3'b011;
    localparam logic [2:0] SelArith = 3'b100;

    localparam logic [4:0] NopRegAddr = 5'b00000;
    localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone, StZero} div_state_e;

    div_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       rem_q, rem_d;
    logic [31:0]       quot_q, quot_d;
    logic [31:0]       dvsr_q, dvsr_d;
    logic              quo_neg_q, quo_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    logic        div_issue, div_signed, stall;
    logic        div_wr;
    logic [31:0] div_hi, div_lo;
    logic [31:0] op1_abs, op2_abs;
    logic [32:0] rem_shift, trial;
    logic [63:0] prod_s, prod_u;
    logic [31:0] alu_res;

    assign div_issue  = ((aluop_i == OpDiv) || (aluop_i == OpDivu)) && !annul_i;
    assign div_signed = (aluop_i == OpDiv);
    assign op1_abs    = (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
    assign op2_abs    = (div_signed && reg2_i[31]) ? -reg2_i : reg2_i;

    // Restoring step: quotient register shifts dividend bits into the remainder.
    assign rem_shift = {rem_q, quot_q[31]};
    assign trial     = rem_shift - {1'b0, dvsr_q};

    assign prod_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
    assign prod_u = {32'b0, reg1_i} * {32'b0, reg2_i};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        dvsr_d    = dvsr_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        stall     = 1'b0;
        div_wr    = 1'b0;
        div_hi    = '0;
        div_lo    = '0;
        case (state_q)
            StIdle: begin
                if (div_issue) begin
                    stall = 1'b1;
                    if (reg2_i == 32'b0) begin
                        state_d = StZero;
                    end else begin
                        state_d   = StBusy;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quot_d    = op1_abs;
                        dvsr_d    = op2_abs;
                        quo_neg_d = div_signed && (reg1_i[31] ^ reg2_i[31]);
                        rem_neg_d = div_signed && reg1_i[31];
                    end
                end
            end
            StBusy: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                    if (!trial[32]) begin
                        rem_d  = trial[31:0];
                        quot_d = {quot_q[30:0], 1'b1};
                    end else begin
                        rem_d  = rem_shift[31:0];
                        quot_d = {quot_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                div_wr  = !annul_i;
                div_hi  = rem_neg_q ? -rem_q : rem_q;
                div_lo  = quo_neg_q ? -quot_q : quot_q;
            end
            StZero: begin
                state_d = StIdle;
                div_wr  = !annul_i;
                div_hi  = reg1_i;
                div_lo  = 32'hFFFF_FFFF;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_wr) begin
            hi_d = div_hi;
            lo_d = div_lo;
        end else begin
            case (aluop_i)
                OpMult:  {hi_d, lo_d} = prod_s;
                OpMultu: {hi_d, lo_d} = prod_u;
                OpMthi:  hi_d = reg1_i;
                OpMtlo:  lo_d = reg1_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            dvsr_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            dvsr_q    <= dvsr_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        alu_res = '0;
        case (alusel_i)
            SelLogic: begin
                case (aluop_i)
                    OpAnd:   alu_res = reg1_i & reg2_i;
                    OpOr:    alu_res = reg1_i | reg2_i;
                    OpXor:   alu_res = reg1_i ^ reg2_i;
                    OpNor:   alu_res = ~(reg1_i | reg2_i);
                    default: alu_res = '0;
                endcase
            end
            SelShift: begin
                case (aluop_i)
                    OpSll:   alu_res = reg1_i << reg2_i[4:0];
                    OpSrl:   alu_res = reg1_i >> reg2_i[4:0];
                    OpSra:   alu_res = $signed(reg1_i) >>> reg2_i[4:0];
                    default: alu_res = '0;
                endcase
            end
            SelArith: begin
                case (aluop_i)
                    OpAdd, OpAddu: alu_res = reg1_i + reg2_i;
                    OpSub, OpSubu: alu_res = reg1_i - reg2_i;
                    OpSlt:   alu_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
                    OpSltu:  alu_res = {31'b0, reg1_i < reg2_i};
                    default: alu_res = '0;
                endcase
            end
            SelMove: begin
                case (aluop_i)
                    OpMfhi:  alu_res = hi_q;
                    OpMflo:  alu_res = lo_q;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Outputs are forced to their idle values while reset is asserted.
    assign wd_o       = rst ? wd_i : NopRegAddr;
    assign wreg_o     = rst & wreg_i;
    assign wdata_o    = rst ? alu_res : 32'b0;
    assign stallreq_o = rst & stall;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule
